// File: rtl/beinmotion_ps2_rx_if.sv
// Avalon-MM slave bus bundle for the PS/2 receive controller.
// The bus master drives the strobes and address; the slave returns registered readdata.
interface beinmotion_ps2_rx_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport slave (
        input  address,
        input  chipselect,
        input  read_n,
        input  write_n,
        input  writedata,
        output readdata
    );

    modport master (
        output address,
        output chipselect,
        output read_n,
        output write_n,
        output writedata,
        input  readdata
    );
endinterface

// File: rtl/beinmotion_ps2_rx.sv
// PS/2 device-to-host receiver: filtered clock edge detection, 11-bit frame FSM,
// receive FIFO and a 4-word Avalon-MM register file with a maskable level IRQ.
module beinmotion_ps2_rx #(
    parameter int FIFO_DEPTH     = 4,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                 clk,
    input  logic                 reset,
    beinmotion_ps2_rx_if.slave   bus,
    output logic                 irq,
    input  logic                 ps2_clk,
    input  logic                 ps2_dat
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TIME_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_clk, fall_stb;
    logic [FW-1:0] filt_cnt;

    state_t        state;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          perr;
    logic [TW-1:0] timer;
    logic          push_req, frame_set;
    logic [8:0]    push_word;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    mask;
    logic          enable, overrun, frame_err;

    logic          wr_sel, rd_sel, not_empty, full, pop, flush, accept, ovr_evt;
    logic          clr_ovr, clr_ferr;
    logic [8:0]    head;
    logic          unused_bits;

    // Pins idle high, so the synchronizers and filter reset to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall_stb <= 1'b0;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            dat_s1   <= ps2_dat;
            dat_s2   <= dat_s1;
            fall_stb <= 1'b0;
            if (clk_s2 != filt_clk) begin
                if (filt_cnt == FILT_LAST) begin
                    filt_clk <= clk_s2;
                    filt_cnt <= '0;
                    fall_stb <= ~clk_s2;
                end else begin
                    filt_cnt <= filt_cnt + FW'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            perr      <= 1'b0;
            timer     <= '0;
            push_req  <= 1'b0;
            push_word <= '0;
            frame_set <= 1'b0;
        end else begin
            push_req  <= 1'b0;
            frame_set <= 1'b0;
            if (!enable) begin
                state <= IDLE;
                timer <= '0;
            end else if (state != IDLE && !fall_stb && timer == TIME_LAST) begin
                state     <= IDLE;
                timer     <= '0;
                frame_set <= 1'b1;
            end else if (fall_stb) begin
                timer <= '0;
                case (state)
                    IDLE: begin
                        if (!dat_s2) begin
                            state  <= DATA;
                            bitcnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg  <= {dat_s2, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        perr  <= ~(^{shreg, dat_s2});
                        state <= STOP;
                    end
                    STOP: begin
                        if (dat_s2) begin
                            push_req  <= 1'b1;
                            push_word <= {perr, shreg};
                        end else begin
                            frame_set <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                timer <= timer + TW'(1);
            end
        end
    end

    assign wr_sel    = bus.chipselect & ~bus.write_n;
    assign rd_sel    = bus.chipselect & ~bus.read_n;
    assign not_empty = (count != '0);
    assign full      = (count == FULL_CNT);
    assign pop       = rd_sel & (bus.address == 2'd0) & not_empty;
    assign flush     = wr_sel & (bus.address == 2'd3) & bus.writedata[1];
    assign accept    = push_req & (~full | pop);
    assign ovr_evt   = push_req & full & ~pop;
    assign clr_ovr   = wr_sel & (bus.address == 2'd1) & bus.writedata[2];
    assign clr_ferr  = wr_sel & (bus.address == 2'd1) & bus.writedata[3];
    assign head      = mem[rd_ptr];
    assign irq       = (mask[0] & not_empty) | (mask[1] & (overrun | frame_err));
    assign unused_bits = ^bus.writedata[31:4];

    always_ff @(posedge clk) begin
        if (accept && !flush)
            mem[wr_ptr] <= push_word;
    end

    // Flush overrides any coincident push or pop; error flag sets win over write-1-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            mask         <= '0;
            enable       <= 1'b0;
            overrun      <= 1'b0;
            frame_err    <= 1'b0;
            bus.readdata <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (accept)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                case ({accept, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end

            overrun   <= (overrun & ~clr_ovr) | ovr_evt;
            frame_err <= (frame_err & ~clr_ferr) | frame_set;

            if (wr_sel && bus.address == 2'd2)
                mask <= bus.writedata[1:0];
            if (wr_sel && bus.address == 2'd3)
                enable <= bus.writedata[0];

            if (rd_sel) begin
                case (bus.address)
                    2'd0:    bus.readdata <= not_empty ? {22'd0, head[8], 1'b1, head[7:0]} : 32'd0;
                    2'd1:    bus.readdata <= {24'd0, 4'(count), frame_err, overrun, full, not_empty};
                    2'd2:    bus.readdata <= {30'd0, mask};
                    default: bus.readdata <= {31'd0, enable};
                endcase
            end
        end
    end
endmodule
